// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: sequencing front end for the seq_multiplier shift-add core.
// Accepts operand pairs on a valid/ready handshake and drives the core's
// load/enable pins for one load cycle and BIT_WIDTH shift cycles. It then
// captures the product and returns it on a second valid/ready handshake.
// Optional feature macro: SEQ_MULT_CTRL_ZERO_BYPASS_EN. When it is defined,
// pairs with a zero operand skip the core and return 0 one cycle after accept.
module seq_mult_ctrl #(
   parameter int unsigned BIT_WIDTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [BIT_WIDTH-1:0]       in_a,
   input  logic [BIT_WIDTH-1:0]       in_b,
   output logic                       mult_load,
   output logic                       mult_enable,
   output logic [BIT_WIDTH-1:0]       mult_factor1,
   output logic [BIT_WIDTH-1:0]       mult_factor2,
   input  logic [2*BIT_WIDTH-1:0]     mult_product,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [2*BIT_WIDTH-1:0]     res_data,
   output logic                       busy
);

   localparam int unsigned CW = $clog2(BIT_WIDTH) + 1;
   // Five states need three bits, so the state register never drops below 3.
   localparam int unsigned SW = (CW < 3) ? 3 : CW;
   localparam logic [CW-1:0] CNT_LAST = CW'(BIT_WIDTH - 1);

   typedef enum logic [SW-1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_CAPT,
      S_DONE
   } state_t;

   state_t                   r_state;
   logic [CW-1:0]            r_cnt;
   logic [BIT_WIDTH-1:0]     r_op_a;
   logic [BIT_WIDTH-1:0]     r_op_b;
   logic [2*BIT_WIDTH-1:0]   r_res_data;
   logic                     r_res_valid;

   logic                     w_in_ready;
   logic                     w_load;
   logic                     w_enable;
   logic                     w_busy;

   // Sequencing FSM: operand capture, shift counting, and result registering.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_op_a      <= '0;
         r_op_b      <= '0;
         r_res_data  <= '0;
         r_res_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_op_a <= in_a;
                  r_op_b <= in_b;
`ifdef SEQ_MULT_CTRL_ZERO_BYPASS_EN
                  if ((in_a == '0) || (in_b == '0)) begin
                     r_res_data  <= '0;
                     r_res_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end else begin
                     r_state <= S_LOAD;
                  end
`else
                  r_state <= S_LOAD;
`endif
               end
            end
            S_LOAD: begin
               r_cnt   <= '0;
               r_state <= S_RUN;
            end
            S_RUN: begin
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == CNT_LAST) begin
                  r_state <= S_CAPT;
               end
            end
            S_CAPT: begin
               r_res_data  <= mult_product;
               r_res_valid <= 1'b1;
               r_state     <= S_DONE;
            end
            S_DONE: begin
               // res_valid is always high in DONE, so res_ready alone completes the handshake.
               if (res_ready) begin
                  r_res_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Core control and handshake outputs are decoded from the state alone.
   always_comb begin
      w_in_ready = 1'b0;
      w_load     = 1'b0;
      w_enable   = 1'b0;
      w_busy     = 1'b1;
      case (r_state)
         S_IDLE: begin
            w_in_ready = 1'b1;
            w_busy     = 1'b0;
         end
         S_LOAD:  w_load   = 1'b1;
         S_RUN:   w_enable = 1'b1;
         default: ;
      endcase
   end

   assign in_ready     = w_in_ready;
   assign busy         = w_busy;
   assign mult_load    = w_load;
   assign mult_enable  = w_enable;
   assign mult_factor1 = r_op_a;
   assign mult_factor2 = r_op_b;
   assign res_valid    = r_res_valid;
   assign res_data     = r_res_data;

endmodule
